// File: rtl/td4_step_ctrl_if.sv
// td4_step_ctrl_if: buttons, breakpoint and core readback in, enables out.
// master drives buttons/pc/op/im/bp; slave (controller) drives cpu_en/state/flags.
interface td4_step_ctrl_if;
  logic       run_btn;
  logic       step_btn;
  logic       bp_en;
  logic [3:0] bp_addr;
  logic [3:0] pc;
  logic [3:0] op;
  logic [3:0] im;
  logic       cpu_en;
  logic [1:0] state;
  logic       bp_hit;
  logic       done;

  modport master (
    output run_btn, step_btn, bp_en, bp_addr,
    output pc, op, im,
    input  cpu_en, state, bp_hit, done
  );

  modport slave (
    input  run_btn, step_btn, bp_en, bp_addr,
    input  pc, op, im,
    output cpu_en, state, bp_hit, done
  );
endinterface

// File: rtl/td4_step_ctrl.sv
// td4_step_ctrl: TD4 run/halt/step controller issuing one-cycle cpu_en pulses.
// Ports: clk, rst (sync, active-high), bus (slave: buttons, bp, pc/op/im in; cpu_en/state/bp_hit/done out).
module td4_step_ctrl #(
  parameter int DIV_LEN = 50000000,
  parameter int DEB_LEN = 1000000
) (
  input logic            clk,
  input logic            rst,
  td4_step_ctrl_if.slave bus
);

  localparam int DW = (DIV_LEN > 1) ? $clog2(DIV_LEN) : 1;
  localparam int CW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } state_t;

  // Button index 0 = run, 1 = step.
  logic [1:0]    raw;
  logic [1:0]    s0;
  logic [1:0]    s1;
  logic [1:0]    deb;
  logic [1:0]    press;
  logic [CW-1:0] cnt [2];

  assign raw = {bus.step_btn, bus.run_btn};

  always_ff @(posedge clk) begin
    if (rst) begin
      s0     <= '0;
      s1     <= '0;
      deb    <= '0;
      press  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s0 <= raw;
      s1 <= s0;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (s1[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEB_LEN - 1)) begin
          deb[i]   <= s1[i];
          cnt[i]   <= '0;
          press[i] <= s1[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t        st, st_n;
  logic [DW-1:0] div, div_n;
  logic          skip, skip_n;
  logic          en_q, en_n;
  logic          bp_q, bp_n;
  logic          dn_q, dn_n;
  logic          run_p, step_p;
  logic          tick, bp_match, self_jmp;

  assign run_p    = press[0];
  assign step_p   = press[1];
  assign tick     = (div == DW'(DIV_LEN - 1));
  assign bp_match = bus.bp_en && (bus.pc == bus.bp_addr);
  assign self_jmp = (bus.op == 4'hF) && (bus.im == bus.pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= HALT;
      div  <= '0;
      skip <= 1'b0;
      en_q <= 1'b0;
      bp_q <= 1'b0;
      dn_q <= 1'b0;
    end else begin
      st   <= st_n;
      div  <= div_n;
      skip <= skip_n;
      en_q <= en_n;
      bp_q <= bp_n;
      dn_q <= dn_n;
    end
  end

  always_comb begin
    st_n   = st;
    div_n  = '0;
    skip_n = skip;
    en_n   = 1'b0;
    bp_n   = bp_q;
    dn_n   = dn_q;
    unique case (st)
      HALT: begin
        if (run_p) begin
          st_n   = RUN;
          skip_n = 1'b1;
          bp_n   = 1'b0;
          dn_n   = 1'b0;
        end else if (step_p) begin
          st_n = STEP;
          en_n = 1'b1;
          bp_n = 1'b0;
          dn_n = 1'b0;
        end
      end
      RUN: begin
        div_n = tick ? '0 : div + 1'b1;
        if (run_p) begin
          st_n  = HALT;
          div_n = '0;
        end else if (tick) begin
          // skip lets a resume execute the instruction it stopped on.
          if (bp_match && !skip) begin
            st_n = HALT;
            bp_n = 1'b1;
          end else if (self_jmp) begin
            st_n = HALT;
            dn_n = 1'b1;
          end else begin
            en_n   = 1'b1;
            skip_n = 1'b0;
          end
        end
      end
      STEP: st_n = HALT;
      default: st_n = HALT;
    endcase
  end

  assign bus.cpu_en = en_q;
  assign bus.state  = st;
  assign bus.bp_hit = bp_q;
  assign bus.done   = dn_q;

endmodule

// File: tb/tb_td4_step_ctrl.sv
// tb_td4_step_ctrl: randomized and directed checks of td4_step_ctrl
// against an event-level reference model of buttons and run/halt/step.
module tb_td4_step_ctrl;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  td4_step_ctrl_if bus ();

  td4_step_ctrl #(
    .DIV_LEN(DIV),
    .DEB_LEN(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [3:0] mem_op [16];
  logic [3:0] mem_im [16];

  // Reference model: raw sample history per button, mode, run start edge.
  bit hist [2][DEB+2];
  bit mdeb [2];
  bit mpend [2];
  int k = 0;
  int mmode;
  int e0;
  bit mskip, men, mbp, mdn;

  task automatic m_reset();
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < DEB + 2; j++) hist[b][j] = 1'b0;
      mdeb[b]  = 1'b0;
      mpend[b] = 1'b0;
    end
    mmode = 0;
    e0    = 0;
    mskip = 0;
    men   = 0;
    mbp   = 0;
    mdn   = 0;
  endtask

  task automatic m_edge();
    bit raw [2];
    bit rp, sp;
    int ones;
    k++;
    if (rst) begin
      m_reset();
      return;
    end
    rp = mpend[0];
    sp = mpend[1];
    raw[0] = bus.run_btn;
    raw[1] = bus.step_btn;
    for (int b = 0; b < 2; b++) begin
      for (int j = DEB + 1; j > 0; j--) hist[b][j] = hist[b][j-1];
      hist[b][0] = raw[b];
      ones = 0;
      for (int j = 2; j <= DEB + 1; j++) ones += int'(hist[b][j]);
      mpend[b] = 1'b0;
      if (!mdeb[b] && ones == DEB) begin
        mdeb[b]  = 1'b1;
        mpend[b] = 1'b1;
      end else if (mdeb[b] && ones == 0) begin
        mdeb[b] = 1'b0;
      end
    end
    men = 0;
    case (mmode)
      0: begin
        if (rp) begin
          mmode = 1; e0 = k; mskip = 1; mbp = 0; mdn = 0;
        end else if (sp) begin
          mmode = 2; men = 1; mbp = 0; mdn = 0;
        end
      end
      1: begin
        if (rp) mmode = 0;
        else if ((k - e0) % DIV == 0) begin
          if (bus.bp_en && bus.pc == bus.bp_addr && !mskip) begin
            mmode = 0; mbp = 1;
          end else if (bus.op == 4'hF && bus.im == bus.pc) begin
            mmode = 0; mdn = 1;
          end else begin
            men = 1; mskip = 0;
          end
        end
      end
      default: mmode = 0;
    endcase
  endtask

  int cyc_n = 0;
  int pulses = 0;
  logic [3:0] exec_pc;

  task automatic set_pc(input logic [3:0] v);
    bus.pc = v;
    bus.op = mem_op[v];
    bus.im = mem_im[v];
  endtask

  task automatic cyc();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    cyc_n++;
    chk("state", bus.state, mmode);
    chk("cpu_en", bus.cpu_en, men);
    chk("bp_hit", bus.bp_hit, mbp);
    chk("done", bus.done, mdn);
    if (bus.cpu_en) begin
      pulses++;
      exec_pc = bus.pc;
      set_pc(bus.pc + 4'd1);
    end
  endtask

  task automatic wait_state(input string tag, input int s, input int budget);
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (bus.state == s) break;
    end
    chk(tag, bus.state, s);
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (bus.cpu_en) break;
    end
    chk(tag, bus.cpu_en, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_run, np, hold;
    int tp [4];
    for (int i = 0; i < 16; i++) begin
      mem_op[i] = 4'($urandom_range(0, 14));
      mem_im[i] = 4'($urandom_range(0, 15));
    end
    rst = 1'b1;
    bus.run_btn  = 1'b0;
    bus.step_btn = 1'b0;
    bus.bp_en    = 1'b0;
    bus.bp_addr  = 4'd0;
    set_pc(4'd0);
    m_reset();
    repeat (2) cyc();
    rst = 1'b0;

    pulses = 0;
    repeat (50) cyc();
    chk("idle_pulses", pulses, 0);

    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      bus.step_btn = (i % 2 == 0);
      cyc();
    end
    bus.step_btn = 1'b1;
    repeat (12) cyc();
    bus.step_btn = 1'b0;
    repeat (12) cyc();
    chk("step_pulses", pulses, 1);

    bus.run_btn = 1'b1;
    wait_state("run_enter", 1, 20);
    t_run = cyc_n;
    np = 0;
    for (int i = 0; i < 40 && np < 4; i++) begin
      cyc();
      if (bus.cpu_en) begin
        tp[np] = cyc_n;
        np++;
      end
    end
    chk("run_npulse", np, 4);
    chk("run_to_pulse", tp[0] - t_run, DIV);
    for (int i = 1; i < 4; i++) chk("run_gap", tp[i] - tp[i-1], DIV);
    bus.run_btn = 1'b0;
    repeat (DEB + 4) cyc();
    bus.run_btn = 1'b1;
    wait_state("run_stop", 0, 20);
    pulses = 0;
    bus.run_btn = 1'b0;
    repeat (20) cyc();
    chk("stop_pulses", pulses, 0);

    set_pc(4'd0);
    bus.bp_en   = 1'b1;
    bus.bp_addr = 4'd3;
    pulses = 0;
    bus.run_btn = 1'b1;
    wait_state("bp_run", 1, 20);
    bus.run_btn = 1'b0;
    wait_state("bp_halt", 0, 40);
    chk("bp_pulses", pulses, 3);
    chk("bp_flag", bus.bp_hit, 1);
    chk("bp_pc", bus.pc, 3);
    bus.run_btn = 1'b1;
    wait_state("resume_run", 1, 20);
    chk("resume_bp_clr", bus.bp_hit, 0);
    bus.run_btn = 1'b0;
    wait_pulse("resume_pulse", 20);
    chk("resume_pc", exec_pc, 3);
    repeat (2) cyc();
    bus.run_btn = 1'b1;
    wait_state("resume_stop", 0, 20);
    bus.run_btn = 1'b0;
    bus.bp_en = 1'b0;
    repeat (DEB + 4) cyc();

    mem_op[5] = 4'hF;
    mem_im[5] = 4'h5;
    set_pc(4'd5);
    pulses = 0;
    bus.run_btn = 1'b1;
    wait_state("sj_run", 1, 20);
    bus.run_btn = 1'b0;
    wait_state("sj_halt", 0, 20);
    chk("sj_done", bus.done, 1);
    chk("sj_pulses", pulses, 0);
    repeat (DEB + 4) cyc();
    bus.step_btn = 1'b1;
    wait_pulse("sj_step", 20);
    chk("sj_done_clr", bus.done, 0);
    bus.step_btn = 1'b0;
    repeat (DEB + 4) cyc();
    chk("sj_step_pulses", pulses, 1);
    mem_op[5] = 4'($urandom_range(0, 14));

    bus.run_btn  = 1'b1;
    bus.step_btn = 1'b1;
    for (int i = 0; i < 20 && bus.state == 0; i++) cyc();
    chk("simul_state", bus.state, 1);
    bus.run_btn  = 1'b0;
    bus.step_btn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mmode == 1 && (k + 1 - e0) % DIV == 0) break;
      cyc();
    end
    rst = 1'b1;
    cyc();
    chk("rst_cpu_en", bus.cpu_en, 0);
    chk("rst_state", bus.state, 0);
    rst = 1'b0;
    repeat (DEB + 4) cyc();

    for (int seg = 0; seg < 200; seg++) begin
      bus.run_btn  = ($urandom_range(0, 3) == 0);
      bus.step_btn = ($urandom_range(0, 3) == 0);
      bus.bp_en    = $urandom_range(0, 1) != 0;
      bus.bp_addr  = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 40) == 0);
      hold = $urandom_range(1, 12);
      repeat (hold) cyc();
      rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
